// File: rtl/fod_dcw_decoder_if.sv
// Control-word / phase-return bus between the FOD loop controller (master)
// and the edge-timing decoder (slave).
interface fod_dcw_decoder_if #(
   parameter int WF       = 16,
   parameter int REF_LOG2 = 1
);
   // DCWs are level signals sampled only on the decoder's LOAD cycle and on
   // FOD_TICK cycles. PHE_VALID is a one-cycle pulse meaning PHE/EDGE_PHASE
   // were updated this cycle; there is no ready/backpressure on either path.
   logic [5:0]              MMD_DCW;
   logic                    RT_DCW;
   logic [9:0]              DTC_DCW;
   logic                    FOD_TICK;
   logic [2:0]              PHE;
   logic                    PHE_VALID;
   logic [REF_LOG2+WF-1:0]  EDGE_PHASE;
   logic                    RANGE_ERR;
   logic                    DBG_STATE;

   modport master (
      output MMD_DCW, RT_DCW, DTC_DCW,
      input  FOD_TICK, PHE, PHE_VALID, EDGE_PHASE, RANGE_ERR, DBG_STATE
   );

   modport slave (
      input  MMD_DCW, RT_DCW, DTC_DCW,
      output FOD_TICK, PHE, PHE_VALID, EDGE_PHASE, RANGE_ERR, DBG_STATE
   );
endinterface

// File: rtl/fod_dcw_decoder.sv
// FOD edge-timing decoder: divides CLK by MMD_DCW and returns each edge's phase
// vs the aux reference. Optional bowed DTC INL model: define FOD_DEC_DTCINL_EN.
module fod_dcw_decoder #(
   parameter int WF        = 16,
   parameter int REF_LOG2  = 1,
   parameter int DTC_LSB   = 84,
   parameter int MMD_MIN   = 4,
   parameter int INL_SHIFT = 14
) (
   input  logic               CLK,
   input  logic               NARST,
   fod_dcw_decoder_if.slave   bus
);

   localparam int EW = REF_LOG2 + WF;
   localparam int FW = 10 + WF;
   localparam int SW = (EW > FW) ? EW : FW;
   // Largest value of d*(1023-d) sizes the effective DTC code in both builds.
   localparam int INL_MAX   = 261632 >> INL_SHIFT;
   localparam int DTC_EFF_W = $clog2(1024 + INL_MAX);

   localparam logic [0:0] ST_LOAD  = 1'b0;
   localparam logic [0:0] ST_COUNT = 1'b1;

   logic [0:0]    state;
   logic [5:0]    cnt;
   logic [5:0]    mmd_l;
   logic          rt_l;
   logic [9:0]    dtc_l;
   logic [EW-1:0] base_phase;
   logic [EW-1:0] edge_phase_q;
   logic [2:0]    phe_q;
   logic          phe_valid_q;
   logic          range_err_q;

   logic          mmd_low;
   logic [5:0]    mmd_clamped;
   logic          tick;
   logic          sample;

   logic [DTC_EFF_W-1:0] dtc_eff;
   logic [FW-1:0]        frac;
   logic [EW-1:0]        base_next;
   logic [EW-1:0]        edge_next;

   assign mmd_low     = bus.MMD_DCW < 6'(MMD_MIN);
   assign mmd_clamped = mmd_low ? 6'(MMD_MIN) : bus.MMD_DCW;
   assign tick        = (state == ST_COUNT) && (cnt == 6'd0);
   assign sample      = (state == ST_LOAD) || tick;

`ifdef FOD_DEC_DTCINL_EN
   logic [19:0] inl_prod;
   assign inl_prod = 20'(dtc_l) * (20'd1023 - 20'(dtc_l));
   assign dtc_eff  = DTC_EFF_W'(dtc_l) + DTC_EFF_W'(inl_prod >> INL_SHIFT);
`else
   assign dtc_eff  = DTC_EFF_W'(dtc_l);
`endif

   // Edge of the period that is ending: latches still hold its start-of-period DCWs.
   assign frac      = (FW'(rt_l) << (WF - 1)) + FW'(dtc_eff) * FW'(DTC_LSB);
   assign base_next = EW'(SW'(base_phase) + (SW'(mmd_l) << WF));
   assign edge_next = EW'(SW'(base_next) + SW'(frac));

   always_ff @(posedge CLK or negedge NARST) begin
      if (!NARST) begin
         state       <= ST_LOAD;
         cnt         <= 6'd0;
         mmd_l       <= 6'd0;
         rt_l        <= 1'b0;
         dtc_l       <= 10'd0;
         range_err_q <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               state <= ST_COUNT;
            end
            default: begin
               state <= ST_COUNT;
            end
         endcase
         if (sample) begin
            mmd_l <= mmd_clamped;
            rt_l  <= bus.RT_DCW;
            dtc_l <= bus.DTC_DCW;
            cnt   <= mmd_clamped - 6'd1;
            if (mmd_low) begin
               range_err_q <= 1'b1;
            end
         end else begin
            cnt <= cnt - 6'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge NARST) begin
      if (!NARST) begin
         base_phase   <= '0;
         edge_phase_q <= '0;
         phe_q        <= 3'd0;
         phe_valid_q  <= 1'b0;
      end else begin
         phe_valid_q <= tick;
         if (tick) begin
            base_phase   <= base_next;
            edge_phase_q <= edge_next;
            phe_q        <= edge_next[EW-1 -: 3];
         end
      end
   end

   assign bus.FOD_TICK   = tick;
   assign bus.PHE        = phe_q;
   assign bus.PHE_VALID  = phe_valid_q;
   assign bus.EDGE_PHASE = edge_phase_q;
   assign bus.RANGE_ERR  = range_err_q;
   assign bus.DBG_STATE  = state;

   a_valid_follows_tick : assert property (
      @(posedge CLK) disable iff (!NARST) tick |=> bus.PHE_VALID);
   a_no_back_to_back_tick : assert property (
      @(posedge CLK) disable iff (!NARST) tick |=> !tick);
   a_ratio_legal : assert property (
      @(posedge CLK) disable iff (!NARST) (state == ST_COUNT) |-> (mmd_l >= 6'(MMD_MIN)));

endmodule

// File: tb/tb_fod_dcw_decoder.sv
// Bench for fod_dcw_decoder: random DCWs against an absolute-time edge model,
// scoreboard queues drained by an independent monitor.
module tb_fod_dcw_decoder;

   localparam int WF       = 16;
   localparam int REF_LOG2 = 1;
   localparam int EW       = REF_LOG2 + WF;
   localparam int DTC_LSB  = 84;
   localparam int MMD_MIN  = 4;
   localparam int W        = 32 + EW;

   logic clk   = 1'b0;
   logic narst = 1'b0;

   logic [5:0] drv_mmd = 6'd4;
   logic       drv_rt  = 1'b0;
   logic [9:0] drv_dtc = 10'd0;

   fod_dcw_decoder_if #(.WF(WF), .REF_LOG2(REF_LOG2)) bus ();

   assign bus.MMD_DCW = drv_mmd;
   assign bus.RT_DCW  = drv_rt;
   assign bus.DTC_DCW = drv_dtc;

   fod_dcw_decoder #(.WF(WF), .REF_LOG2(REF_LOG2)) dut (
      .CLK   (clk),
      .NARST (narst),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0]  exp_q[$];
   logic [31:0]   tick_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;

   int            cyc = 0;
   int            next_sample = 1;
   longint        t_abs = 0;
   bit            have_prev = 0;
   int            prev_p = 0;
   bit            prev_rt = 0;
   int            prev_dtc = 0;
   int            cur_p = 0;
   bit            range_sticky = 0;
   bit            req_final = 0;
   bit            final_done = 0;

   function automatic int dtc_eff(int d);
`ifdef FOD_DEC_DTCINL_EN
      return d + ((d * (1023 - d)) >> 14);
`else
      return d;
`endif
   endfunction

   // Edge time = total elapsed CLK periods plus fractional delay, modulo the reference.
   function automatic logic [EW-1:0] ref_edge(longint t, bit rt, int dtc);
      longint v;
      longint modv;
      v    = (t << WF) + (rt ? (longint'(1) << (WF - 1)) : longint'(0))
           + longint'(dtc_eff(dtc)) * DTC_LSB;
      modv = longint'(1) << EW;
      return EW'(v % modv);
   endfunction

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, expv, cyc);
      end
   endfunction

   // ---------------- reference model ----------------
   always @(posedge clk) begin
      if (!narst) begin
         cyc          = 0;
         next_sample  = 1;
         t_abs        = 0;
         have_prev    = 0;
         range_sticky = 0;
         exp_q.delete();
         tick_q.delete();
      end else begin
         cyc++;
         if (cyc == next_sample) begin
            cur_p = (int'(drv_mmd) < MMD_MIN) ? MMD_MIN : int'(drv_mmd);
            if (int'(drv_mmd) < MMD_MIN) range_sticky = 1;
            if (have_prev) begin
               t_abs += prev_p;
               exp_q.push_back({32'(cyc), ref_edge(t_abs, prev_rt, prev_dtc)});
            end
            prev_p      = cur_p;
            prev_rt     = drv_rt;
            prev_dtc    = int'(drv_dtc);
            have_prev   = 1;
            next_sample = cyc + cur_p;
            tick_q.push_back(32'(next_sample - 1));
         end
      end
   end

   // ---------------- monitor ----------------
   logic [2:0]    last_phe = 3'd0;
   logic [W-1:0]  ent;
   logic [EW-1:0] exp_edge;
   bit            exp_tick;
   bit            exp_valid;

   always @(negedge clk) begin
      if (req_final && !final_done) begin
         chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
         chk("tick_q_pending", 64'(tick_q.size() <= 1), 64'd1);
         final_done = 1;
      end
      if (!narst) begin
         chk("rst_fod_tick",   64'(bus.FOD_TICK),   64'd0);
         chk("rst_phe_valid",  64'(bus.PHE_VALID),  64'd0);
         chk("rst_phe",        64'(bus.PHE),        64'd0);
         chk("rst_edge_phase", 64'(bus.EDGE_PHASE), 64'd0);
         chk("rst_range_err",  64'(bus.RANGE_ERR),  64'd0);
         chk("rst_state",      64'(bus.DBG_STATE),  64'd0);
         last_phe = 3'd0;
      end else begin
         exp_tick = (tick_q.size() > 0) && (tick_q[0] == 32'(cyc));
         chk("fod_tick", 64'(bus.FOD_TICK), 64'(exp_tick));
         if (exp_tick) void'(tick_q.pop_front());

         exp_valid = 0;
         if (exp_q.size() > 0) begin
            ent = exp_q[0];
            exp_valid = (ent[W-1 -: 32] == 32'(cyc));
         end
         chk("phe_valid", 64'(bus.PHE_VALID), 64'(exp_valid));
         if (exp_valid) begin
            ent      = exp_q.pop_front();
            exp_edge = ent[EW-1:0];
            chk("edge_phase", 64'(bus.EDGE_PHASE), 64'(exp_edge));
            last_phe = exp_edge[EW-1 -: 3];
         end
         chk("phe", 64'(bus.PHE), 64'(last_phe));
         chk("range_err", 64'(bus.RANGE_ERR), 64'(range_sticky));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_dcw(input int m, input int r, input int d);
      @(negedge clk);
      drv_mmd = 6'(m);
      drv_rt  = r[0];
      drv_dtc = 10'(d);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 narst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 narst = 1'b1;
   endtask

   task automatic random_phase(input int n, input bit allow_low);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            if (allow_low && $urandom_range(0, 9) == 0)
               drv_mmd = 6'($urandom_range(0, 3));
            else
               drv_mmd = 6'($urandom_range(4, 63));
            drv_rt  = 1'($urandom_range(0, 1));
            drv_dtc = 10'($urandom_range(0, 1023));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      narst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 narst = 1'b1;

      run(40);                  // MMD=4, RT=0, DTC=0
      set_dcw(5, 0, 0);   run(40);
      set_dcw(4, 1, 0);   run(40);
      set_dcw(4, 0, 390); run(40);
      set_dcw(4, 0, 1023); run(20);
      set_dcw(2, 0, 0);   run(20);
      set_dcw(6, 0, 0);   run(30);

      // Reset with cnt=3 of a 40-cycle period; first tick expected 40 CLK after release.
      set_dcw(40, 0, 0);
      pulse_reset();
      repeat (37) @(posedge clk);
      #1 narst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 narst = 1'b1;
      run(100);

      random_phase(2500, 1'b1);
      pulse_reset();
      random_phase(2500, 1'b0);
      run(70);

      @(negedge clk);
      req_final = 1;
      for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
      if (!final_done) begin
         $display("FAIL final_check: monitor did not respond");
         $fatal(1, "final check timed out");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
